cluster_iterator: RTL

Sequential cluster extractor that sits directly downstream of the 192-pad cluster finder and wraps one `priority_n` encoder, which is combinational in this build. On a start strobe it latches a frame of valid-pattern flags and cluster counts. It then runs the encoder once per clock, masking each winner, until the frame is empty or `MXCLUSTERS` clusters have been collected. The resulting cluster list, ordered lowest address first, feeds the cluster packer/formatter.

---
 rtl/cluster_iterator.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cluster_iterator.sv
// Sequential cluster extractor: latches one frame of pad flags/counts, then peels off
// the lowest-address cluster each clock through a combinational priority encoder.

module priority_n #(
    parameter int MXKEYS    = 192,
    parameter int MXKEYBITS = 8,
    parameter int MXCNTB    = 3
) (
    input  logic [MXKEYS-1:0]        vpfs_i,
    input  logic [MXKEYS*MXCNTB-1:0] cnts_i,
    output logic                     vpf_o,
    output logic [MXKEYBITS-1:0]     adr_o,
    output logic [MXCNTB-1:0]        cnt_o
);
    // Walk from the top down so the lowest set index is the last one written.
    always_comb begin
        vpf_o = |vpfs_i;
        adr_o = '1;
        cnt_o = '0;
        for (int i = MXKEYS - 1; i >= 0; i--) begin
            if (vpfs_i[i]) begin
                adr_o = MXKEYBITS'(i);
                cnt_o = cnts_i[i*MXCNTB +: MXCNTB];
            end
        end
    end
endmodule

// state  | meaning
// IDLE   | waiting for start_i; results held
// LOAD   | frame captured, encoder input settling for the first scan
// SCAN   | one cluster extracted per clock
// DONE   | list final, done_o high for this cycle
module cluster_iterator #(
    parameter int MXKEYS     = 192,
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     start_i,
    input  logic [MXKEYS-1:0]                        vpfs_i,
    input  logic [MXKEYS*MXCNTB-1:0]                 cnts_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic [MXCLUSTERS*(MXCNTB+MXKEYBITS)-1:0] clusters_o,
    output logic [MXCLUSTERS-1:0]                    valid_o,
    output logic                                     overflow_o,
    output logic                                     lost_o
);
    localparam int SW = MXCNTB + MXKEYBITS;
    localparam int IW = $clog2(MXCLUSTERS);
    localparam logic [SW-1:0] SLOT_EMPTY = {{MXCNTB{1'b0}}, {MXKEYBITS{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [MXKEYS-1:0]               mask_q, mask_d;
    logic [MXKEYS*MXCNTB-1:0]        cntr_q, cntr_d;
    logic [IW:0]                     idx_q, idx_d;
    logic [MXCLUSTERS*SW-1:0]        slots_q, slots_d;
    logic [MXCLUSTERS-1:0]           valid_q, valid_d;
    logic                            ovf_q, ovf_d;
    logic                            lost_q, lost_d;

    logic                            enc_vpf;
    logic [MXKEYBITS-1:0]            enc_adr;
    logic [MXCNTB-1:0]               enc_cnt;

    priority_n #(
        .MXKEYS    (MXKEYS),
        .MXKEYBITS (MXKEYBITS),
        .MXCNTB    (MXCNTB)
    ) u_enc (
        .vpfs_i (mask_q),
        .cnts_i (cntr_q),
        .vpf_o  (enc_vpf),
        .adr_o  (enc_adr),
        .cnt_o  (enc_cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            cntr_q  <= '0;
            idx_q   <= '0;
            slots_q <= {MXCLUSTERS{SLOT_EMPTY}};
            valid_q <= '0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cntr_q  <= cntr_d;
            idx_q   <= idx_d;
            slots_q <= slots_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cntr_d  = cntr_q;
        idx_d   = idx_q;
        slots_d = slots_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        lost_d  = start_i && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mask_d  = vpfs_i;
                    cntr_d  = cnts_i;
                    idx_d   = '0;
                    slots_d = {MXCLUSTERS{SLOT_EMPTY}};
                    valid_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_SCAN;
            S_SCAN: begin
                if (enc_vpf) begin
                    slots_d[idx_q[IW-1:0]*SW +: SW] = {enc_cnt, enc_adr};
                    valid_d[idx_q[IW-1:0]]          = 1'b1;
                    mask_d[enc_adr]                 = 1'b0;
                    idx_d                           = idx_q + 1'b1;
                    // Anything still flagged once the list is full is overflow.
                    if (idx_q == (IW+1)'(MXCLUSTERS - 1)) begin
                        ovf_d   = |mask_d;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q == S_SCAN);
    assign done_o     = (state_q == S_DONE);
    assign clusters_o = slots_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
    assign lost_o     = lost_q;
endmodule
